// File: rtl/bin_to_bcd.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter, one iteration per clock.
// Optional macro BIN_TO_BCD_RESTART_EN: a request while busy aborts and restarts the conversion.
package g;
    typedef logic [11:0] bcd_t;
endpackage

module bin_to_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             bin_in_en,
    input  logic [WIDTH-1:0] bin_in,
    output g::bcd_t          bcd_out,
    output logic             bcd_out_en,
    output logic             busy_out
);

    localparam int unsigned SW = DIGITS * 4;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (SW != $bits(g::bcd_t)) begin : g_bad_digits
        $error("bin_to_bcd: DIGITS*4 must equal the width of g::bcd_t");
    end

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e           state_q;
    logic [SW-1:0]    scratch_q;
    logic [SW-1:0]    scratch_adj;
    logic [WIDTH-1:0] bin_q;
    logic [CW-1:0]    cnt_q;
    logic             restart;

`ifdef BIN_TO_BCD_RESTART_EN
    assign restart = bin_in_en && (state_q != StIdle);
`else
    assign restart = 1'b0;
`endif

    // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            scratch_q  <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            bcd_out    <= '0;
            bcd_out_en <= 1'b0;
            busy_out   <= 1'b0;
        end else begin
            bcd_out_en <= 1'b0;
            if (restart) begin
                bin_q     <= bin_in;
                scratch_q <= '0;
                cnt_q     <= CW'(WIDTH);
                busy_out  <= 1'b1;
                state_q   <= StConv;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bin_in_en) begin
                            bin_q     <= bin_in;
                            scratch_q <= '0;
                            cnt_q     <= CW'(WIDTH);
                            busy_out  <= 1'b1;
                            state_q   <= StConv;
                        end
                    end
                    StConv: begin
                        // Carries out of the top digit are dropped: result is value mod 10**DIGITS.
                        {scratch_q, bin_q} <= {scratch_adj, bin_q} << 1;
                        cnt_q              <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        bcd_out    <= scratch_q;
                        bcd_out_en <= 1'b1;
                        busy_out   <= 1'b0;
                        state_q    <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed cases with literal results plus a cycle-level
// behavioural model compared every cycle under exhaustive and random stimulus.
module tb_bin_to_bcd;

    localparam int WIDTH = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        bin_in_en = 1'b0;
    logic [7:0]  bin_in = '0;
    logic [11:0] bcd_out;
    logic        bcd_out_en;
    logic        busy_out;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .bin_in_en  (bin_in_en),
        .bin_in     (bin_in),
        .bcd_out    (bcd_out),
        .bcd_out_en (bcd_out_en),
        .busy_out   (busy_out)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef BIN_TO_BCD_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        int r;
        r = v % 1000;
        return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    // Behavioural model: cycles remaining until the result pulse, and the value being converted.
    int          m_left = 0;
    int          m_val = 0;
    logic [11:0] m_out = '0;
    logic        m_en = 1'b0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_left <= 0;
            m_out  <= '0;
            m_en   <= 1'b0;
        end else begin
            m_en <= 1'b0;
            if (bin_in_en && (m_left == 0 || RESTART)) begin
                m_left <= WIDTH + 1;
                m_val  <= int'(bin_in);
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_en  <= 1'b1;
                    m_out <= to_bcd(m_val);
                end
            end
        end
    end

    logic prev_en = 1'b0;
    always @(negedge sys_clk) begin
        if (started) begin
            chk("bcd_out_en", 32'(bcd_out_en), 32'(m_en));
            chk("busy_out", 32'(busy_out), 32'(m_left > 0));
            chk("bcd_out", 32'(bcd_out), 32'(m_out));
            chk("en_back_to_back", 32'(prev_en && bcd_out_en), 32'd0);
            for (int i = 0; i < 3; i++) begin
                chk("digit_le_9", 32'(bcd_out[i*4 +: 4] > 4'd9), 32'd0);
            end
            prev_en = bcd_out_en;
        end
    end

    task automatic request(input logic [7:0] v);
        @(negedge sys_clk);
        bin_in    = v;
        bin_in_en = 1'b1;
        @(posedge sys_clk);
        #1;
        bin_in_en = 1'b0;
        bin_in    = 8'($urandom);
    endtask

    task automatic collect(input int window, output int first_k, output logic [11:0] val,
                           output int n, output int nbusy);
        first_k = 0;
        val     = '0;
        n       = 0;
        nbusy   = int'(busy_out);
        for (int k = 1; k <= window; k++) begin
            @(posedge sys_clk);
            #1;
            if (busy_out) nbusy++;
            if (bcd_out_en) begin
                n++;
                if (first_k == 0) begin
                    first_k = k;
                    val     = bcd_out;
                end
            end
        end
    endtask

    initial begin
        int          fk, n, nb;
        logic [11:0] val;
        int          vals[6];
        logic [11:0] exps[6];
        vals = '{0, 9, 10, 99, 100, 255};
        exps = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

        #2 sys_rst_n = 1'b0;
        started = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_bcd_out", 32'(bcd_out), 32'h0);
        chk("reset_en", 32'(bcd_out_en), 32'h0);
        chk("reset_busy", 32'(busy_out), 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 128: latency 9, one pulse, busy for 9 cycles
        request(8'd128);
        collect(14, fk, val, n, nb);
        chk("t1_latency", 32'(fk), 32'd9);
        chk("t1_value", 32'(val), 32'h128);
        chk("t1_pulses", 32'(n), 32'd1);
        chk("t1_busy_cycles", 32'(nb), 32'd9);

        foreach (vals[i]) begin
            request(8'(vals[i]));
            collect(12, fk, val, n, nb);
            chk("t2_value", 32'(val), 32'(exps[i]));
            chk("t2_pulses", 32'(n), 32'd1);
        end

        // Back-to-back: second request issued in the result-pulse cycle
        request(8'd200);
        fk = 0;
        for (int k = 1; k <= 20 && fk == 0; k++) begin
            @(posedge sys_clk);
            #1;
            if (bcd_out_en) fk = k;
        end
        chk("t3_first_seen", 32'(fk != 0), 32'd1);
        chk("t3_first_value", 32'(bcd_out), 32'h200);
        bin_in    = 8'd42;
        bin_in_en = 1'b1;
        @(posedge sys_clk);
        #1;
        bin_in_en = 1'b0;
        collect(12, fk, val, n, nb);
        chk("t3_second_latency", 32'(fk), 32'd9);
        chk("t3_second_value", 32'(val), 32'h042);
        chk("t3_second_pulses", 32'(n), 32'd1);

        // Request while busy
        request(8'd5);
        collect(2, fk, val, n, nb);
        chk("t4_early_pulses", 32'(n), 32'd0);
        request(8'd77);
        collect(14, fk, val, n, nb);
        chk("t4_pulses", 32'(n), 32'd1);
`ifdef BIN_TO_BCD_RESTART_EN
        chk("t4_latency", 32'(fk), 32'd9);
        chk("t4_value", 32'(val), 32'h077);
`else
        chk("t4_latency", 32'(fk), 32'd6);
        chk("t4_value", 32'(val), 32'h005);
`endif

        // Reset mid-conversion
        request(8'd150);
        collect(4, fk, val, n, nb);
        sys_rst_n = 1'b0;
        #1;
        chk("t5_rst_bcd_out", 32'(bcd_out), 32'h0);
        chk("t5_rst_busy", 32'(busy_out), 32'h0);
        chk("t5_rst_en", 32'(bcd_out_en), 32'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        collect(12, fk, val, n, nb);
        chk("t5_no_pulse", 32'(n), 32'd0);
        request(8'd63);
        collect(12, fk, val, n, nb);
        chk("t5_value", 32'(val), 32'h063);

        // Exhaustive sweep with random idle gaps; model compare process does the checking
        for (int v = 0; v < 256; v++) begin
            request(8'(v));
            fk = 0;
            for (int k = 1; k <= 20 && fk == 0; k++) begin
                @(posedge sys_clk);
                #1;
                if (bcd_out_en) fk = k;
            end
            chk("t6_pulse_seen", 32'(fk), 32'd9);
            repeat ($urandom_range(0, 2)) @(posedge sys_clk);
        end

        // Random request traffic, including requests while busy
        for (int c = 0; c < 2000; c++) begin
            @(negedge sys_clk);
            bin_in_en = ($urandom_range(0, 5) == 0);
            bin_in    = 8'($urandom);
        end
        @(negedge sys_clk);
        bin_in_en = 1'b0;
        repeat (15) @(posedge sys_clk);
        @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
